// File: rtl/filter_band_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// filtro_pkg
// Shared constants, state encoding and band/address helpers for the
// three-band biquad scheduler (filter_band_scheduler).
// Contents:
//   NBANDS, NTAPS          - fixed band count and taps per biquad section
//   BAND_LOW/MID/HIGH      - band encodings driven on `band`
//   TAP_B0..TAP_A2         - tap indices driven on `tap`
//   state_t                - scheduler FSM state encoding
//   lowest_band()          - first band to process for a given enable mask
//   next_band()            - next higher enabled band, {valid, band}
//   coef_addr_of()         - coefficient ROM address band*5+tap
// -----------------------------------------------------------------------------
package filtro_pkg;

   localparam int NBANDS = 3;
   localparam int NTAPS  = 5;

   localparam logic [1:0] BAND_LOW  = 2'd0;
   localparam logic [1:0] BAND_MID  = 2'd1;
   localparam logic [1:0] BAND_HIGH = 2'd2;

   localparam logic [2:0] TAP_B0 = 3'd0;
   localparam logic [2:0] TAP_B1 = 3'd1;
   localparam logic [2:0] TAP_B2 = 3'd2;
   localparam logic [2:0] TAP_A1 = 3'd3;
   localparam logic [2:0] TAP_A2 = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MAC   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Only called with a non-zero mask; falls through to HIGH otherwise.
   function automatic logic [1:0] lowest_band(input logic [NBANDS-1:0] band_en);
      logic [1:0] b;
      if (band_en[0]) begin
         b = BAND_LOW;
      end else if (band_en[1]) begin
         b = BAND_MID;
      end else begin
         b = BAND_HIGH;
      end
      return b;
   endfunction

   // Returns {1'b1, band} for the next higher enabled band, 3'b000 if none.
   function automatic logic [2:0] next_band(input logic [NBANDS-1:0] band_en,
                                            input logic [1:0]        band);
      logic [2:0] nb;
      nb = 3'b000;
      case (band)
         BAND_LOW: begin
            if (band_en[1]) begin
               nb = {1'b1, BAND_MID};
            end else if (band_en[2]) begin
               nb = {1'b1, BAND_HIGH};
            end else begin
               nb = 3'b000;
            end
         end
         BAND_MID: begin
            if (band_en[2]) begin
               nb = {1'b1, BAND_HIGH};
            end else begin
               nb = 3'b000;
            end
         end
         default: nb = 3'b000;
      endcase
      return nb;
   endfunction

   function automatic logic [3:0] coef_addr_of(input logic [1:0] band,
                                               input logic [2:0] tap);
      return (4'(band) * 4'd5) + 4'(tap);
   endfunction

endpackage

// File: rtl/filter_band_scheduler_if.sv
// -----------------------------------------------------------------------------
// filter_band_scheduler_if
// Bundle between the divider/MAC datapath side (master) and the band
// scheduler (slave).
//   Enable, band_en          - sample strobe and per-band enable (to scheduler)
//   band, tap, coef_addr     - current band/tap and coefficient ROM address
//   mac_en, mac_clr, mac_sub - shared MAC control
//   wb_en, shift_en          - band output write-back and delay-line shift
//   busy, Listo, overrun     - status: sample in flight, sample done, overrun
// -----------------------------------------------------------------------------
interface filter_band_scheduler_if;
   import filtro_pkg::*;

   logic              Enable;
   logic [NBANDS-1:0] band_en;
   logic [1:0]        band;
   logic [2:0]        tap;
   logic [3:0]        coef_addr;
   logic              mac_en;
   logic              mac_clr;
   logic              mac_sub;
   logic              wb_en;
   logic              shift_en;
   logic              busy;
   logic              Listo;
   logic              overrun;

   modport master (
      output Enable, band_en,
      input  band, tap, coef_addr, mac_en, mac_clr, mac_sub,
             wb_en, shift_en, busy, Listo, overrun
   );

   modport slave (
      input  Enable, band_en,
      output band, tap, coef_addr, mac_en, mac_clr, mac_sub,
             wb_en, shift_en, busy, Listo, overrun
   );

endinterface

// File: rtl/filter_band_scheduler_tap_counter.sv
// -----------------------------------------------------------------------------
// tap_counter
// Loadable up-counter shared by the tap walk (0..4) and the MAC drain wait
// (0..MAC_LAT-1). A load restarts the count at zero and latches a new
// terminal value; tc flags that the count has reached it.
//   CLK, Reset - clock, synchronous active-high reset
//   load       - restart at 0 and capture load_term
//   load_term  - terminal value for the next run
//   inc        - advance by one (ignored during load)
//   count      - current count
//   tc         - count == terminal value
// -----------------------------------------------------------------------------
module tap_counter #(
   parameter int W = 3
) (
   input  logic         CLK,
   input  logic         Reset,
   input  logic         load,
   input  logic [W-1:0] load_term,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         tc
);
   import filtro_pkg::*;

   logic [W-1:0] count_r;
   logic [W-1:0] term_r;

   // Count register and latched terminal value.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         count_r <= {W{1'b0}};
         term_r  <= {W{1'b0}};
      end else if (load) begin
         count_r <= {W{1'b0}};
         term_r  <= load_term;
      end else if (inc) begin
         count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign tc    = (count_r == term_r);

endmodule

// File: rtl/filter_band_scheduler.sv
// -----------------------------------------------------------------------------
// filter_band_scheduler
// Time-shares one MAC across the low/mid/high biquad sections. Per accepted
// sample strobe it walks the enabled bands in order: five MAC taps, MAC_LAT
// drain cycles, one write-back/shift cycle; then a one-cycle Listo.
//   CLK    - system clock
//   Reset  - synchronous active-high reset, abandons any sample in flight
//   bus    - filter_band_scheduler_if.slave (strobe in, MAC/status out)
// Parameter MAC_LAT (1..7): MAC latency from last mac_en to valid accumulator.
// -----------------------------------------------------------------------------
module filter_band_scheduler #(
   parameter int MAC_LAT = 2
) (
   input  logic                     CLK,
   input  logic                     Reset,
   filter_band_scheduler_if.slave   bus
);
   import filtro_pkg::*;

   localparam logic [2:0] DRAIN_TERM = 3'(MAC_LAT - 1);

   state_t            state_r;
   logic [NBANDS-1:0] band_en_r;
   logic [1:0]        band_r;
   logic [2:0]        tap_r;
   logic [3:0]        coef_addr_r;
   logic              mac_en_r;
   logic              mac_clr_r;
   logic              mac_sub_r;
   logic              wb_en_r;
   logic              shift_en_r;
   logic              busy_r;
   logic              listo_r;
   logic              overrun_r;

   logic              cnt_load_s;
   logic [2:0]        cnt_term_s;
   logic              cnt_inc_s;
   logic [2:0]        cnt_s;
   logic              cnt_tc_s;
   logic [2:0]        nb_s;

   assign nb_s = next_band(band_en_r, band_r);

   tap_counter #(.W(3)) u_tap_counter (
      .CLK       (CLK),
      .Reset     (Reset),
      .load      (cnt_load_s),
      .load_term (cnt_term_s),
      .inc       (cnt_inc_s),
      .count     (cnt_s),
      .tc        (cnt_tc_s)
   );

   // Counter control: restart for the tap walk on entry to MAC, restart for
   // the drain wait when the last tap issues, otherwise count up.
   always_comb begin
      cnt_load_s = 1'b0;
      cnt_term_s = TAP_A2;
      cnt_inc_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.Enable && (bus.band_en != 3'b000)) begin
               cnt_load_s = 1'b1;
            end else begin
               cnt_load_s = 1'b0;
            end
         end
         ST_MAC: begin
            if (cnt_tc_s) begin
               cnt_load_s = 1'b1;
               cnt_term_s = DRAIN_TERM;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt_tc_s) begin
               cnt_inc_s = 1'b0;
            end else begin
               cnt_inc_s = 1'b1;
            end
         end
         ST_WRITE: cnt_load_s = 1'b1;
         default:  cnt_load_s = 1'b0;
      endcase
   end

   // Scheduler FSM; every output is a register updated on the transition
   // into the cycle where it must be visible.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_r     <= ST_IDLE;
         band_en_r   <= 3'b000;
         band_r      <= 2'd0;
         tap_r       <= 3'd0;
         coef_addr_r <= 4'd0;
         mac_en_r    <= 1'b0;
         mac_clr_r   <= 1'b0;
         mac_sub_r   <= 1'b0;
         wb_en_r     <= 1'b0;
         shift_en_r  <= 1'b0;
         busy_r      <= 1'b0;
         listo_r     <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         if (bus.Enable && busy_r) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end

         case (state_r)
            ST_IDLE: begin
               if (bus.Enable) begin
                  busy_r <= 1'b1;
                  if (bus.band_en != 3'b000) begin
                     state_r     <= ST_MAC;
                     band_en_r   <= bus.band_en;
                     band_r      <= lowest_band(bus.band_en);
                     tap_r       <= TAP_B0;
                     coef_addr_r <= coef_addr_of(lowest_band(bus.band_en), TAP_B0);
                     mac_en_r    <= 1'b1;
                     mac_clr_r   <= 1'b1;
                     mac_sub_r   <= 1'b0;
                  end else begin
                     state_r <= ST_DONE;
                     listo_r <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_MAC: begin
               mac_clr_r <= 1'b0;
               if (cnt_tc_s) begin
                  // Last tap issued: tap and address hold through drain/write.
                  state_r   <= ST_DRAIN;
                  mac_en_r  <= 1'b0;
                  mac_sub_r <= 1'b0;
               end else begin
                  tap_r       <= cnt_s + 3'd1;
                  coef_addr_r <= coef_addr_of(band_r, cnt_s + 3'd1);
                  // Next tap is a1 or a2 (feedback terms are subtracted).
                  mac_sub_r   <= (cnt_s >= TAP_B2);
               end
            end

            ST_DRAIN: begin
               if (cnt_tc_s) begin
                  state_r    <= ST_WRITE;
                  wb_en_r    <= 1'b1;
                  shift_en_r <= 1'b1;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end

            ST_WRITE: begin
               wb_en_r    <= 1'b0;
               shift_en_r <= 1'b0;
               tap_r      <= TAP_B0;
               if (nb_s[2]) begin
                  state_r     <= ST_MAC;
                  band_r      <= nb_s[1:0];
                  coef_addr_r <= coef_addr_of(nb_s[1:0], TAP_B0);
                  mac_en_r    <= 1'b1;
                  mac_clr_r   <= 1'b1;
               end else begin
                  state_r     <= ST_DONE;
                  band_r      <= BAND_LOW;
                  coef_addr_r <= 4'd0;
                  listo_r     <= 1'b1;
               end
            end

            ST_DONE: begin
               state_r <= ST_IDLE;
               listo_r <= 1'b0;
               busy_r  <= 1'b0;
            end

            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.band      = band_r;
   assign bus.tap       = tap_r;
   assign bus.coef_addr = coef_addr_r;
   assign bus.mac_en    = mac_en_r;
   assign bus.mac_clr   = mac_clr_r;
   assign bus.mac_sub   = mac_sub_r;
   assign bus.wb_en     = wb_en_r;
   assign bus.shift_en  = shift_en_r;
   assign bus.busy      = busy_r;
   assign bus.Listo     = listo_r;
   assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_filter_band_scheduler.sv
// -----------------------------------------------------------------------------
// tb_filter_band_scheduler
// Directed bench for filter_band_scheduler: one instance at MAC_LAT=2 and one
// at MAC_LAT=5. Each sample is checked cycle by cycle against the expected
// band/tap timeline, and key event cycles against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_filter_band_scheduler;

   logic CLK = 1'b0;
   logic Reset;

   always #5 CLK = ~CLK;

   filter_band_scheduler_if bus2();
   filter_band_scheduler_if bus5();

   filter_band_scheduler #(.MAC_LAT(2)) dut2 (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus2.slave)
   );

   filter_band_scheduler #(.MAC_LAT(5)) dut5 (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus5.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // {band, tap, coef_addr, mac_en, mac_clr, mac_sub, wb_en, shift_en, busy, Listo}
   function automatic logic [15:0] snap(input int sel);
      if (sel == 0)
         return {bus2.band, bus2.tap, bus2.coef_addr, bus2.mac_en, bus2.mac_clr,
                 bus2.mac_sub, bus2.wb_en, bus2.shift_en, bus2.busy, bus2.Listo};
      else
         return {bus5.band, bus5.tap, bus5.coef_addr, bus5.mac_en, bus5.mac_clr,
                 bus5.mac_sub, bus5.wb_en, bus5.shift_en, bus5.busy, bus5.Listo};
   endfunction

   function automatic logic ovr(input int sel);
      if (sel == 0) return bus2.overrun;
      else          return bus5.overrun;
   endfunction

   function automatic logic [15:0] mk(input int b, input int tp, input logic mac, input logic clr,
                                      input logic sub, input logic wb, input logic bsy, input logic lst);
      logic [1:0] bb;
      logic [2:0] tt;
      logic [3:0] ca;
      bb = 2'(b);
      tt = 3'(tp);
      ca = 4'(b * 5 + tp);
      return {bb, tt, ca, mac, clr, sub, wb, wb, bsy, lst};
   endfunction

   task automatic drive(input int sel, input logic en, input logic [2:0] ben);
      if (sel == 0) begin
         bus2.Enable  = en;
         bus2.band_en = ben;
      end else begin
         bus5.Enable  = en;
         bus5.band_en = ben;
      end
   endtask

   // Strobe Enable with ben, then check every cycle through the first idle
   // cycle after DONE. Extra Enables are injected at cycles inj1/inj2, and
   // band_en is scrambled while busy; neither may disturb the timeline.
   task automatic run_sample(input int sel, input logic [2:0] ben, input int lat,
                             input int inj1, input int inj2, output int listo_at,
                             output int wb0, output int wb1, output int wb2);
      int bl[3];
      int nb, per, tot, idx, o, nwb;
      logic [15:0] e, s;
      nb = 0;
      for (int i = 0; i < 3; i++) begin
         if (ben[i]) begin
            bl[nb] = i;
            nb++;
         end
      end
      per = 6 + lat;
      tot = nb * per + 2;
      listo_at = 0; wb0 = 0; wb1 = 0; wb2 = 0; nwb = 0;
      drive(sel, 1'b1, ben);
      step();
      for (int t = 1; t <= tot; t++) begin
         if (t <= nb * per) begin
            idx = (t - 1) / per;
            o   = (t - 1) % per;
            e = mk(bl[idx], (o < 5) ? o : 4, o < 5, o == 0, (o == 3) || (o == 4),
                   o == per - 1, 1'b1, 1'b0);
         end else if (t == nb * per + 1) begin
            e = mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         end else begin
            e = mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         s = snap(sel);
         check_vec($sformatf("s%0d_en%b_t%0d", sel, ben, t), {16'h0, s}, {16'h0, e});
         if (s[0] && (listo_at == 0)) listo_at = t;
         if (s[3]) begin
            if (nwb == 0) wb0 = t;
            else if (nwb == 1) wb1 = t;
            else wb2 = t;
            nwb++;
         end
         drive(sel, (t == inj1) || (t == inj2), ~ben);
         step();
      end
      drive(sel, 1'b0, ~ben);
   endtask

   initial begin
      int la, w0, w1, w2, hits;
      logic [15:0] s;

      // Reset state
      Reset = 1'b1;
      drive(0, 1'b0, 3'b000);
      drive(1, 1'b0, 3'b000);
      step();
      step();
      check_vec("rst_outs2", {16'h0, snap(0)}, 32'd0);
      check_vec("rst_outs5", {16'h0, snap(1)}, 32'd0);
      check_vec("rst_ovr2", {31'd0, ovr(0)}, 32'd0);
      Reset = 1'b0;
      step();
      check_vec("idle_outs2", {16'h0, snap(0)}, 32'd0);

      // All bands
      run_sample(0, 3'b111, 2, 0, 0, la, w0, w1, w2);
      check_vec("all_listo_at", 32'(la), 32'd25);
      check_vec("all_wb0_at", 32'(w0), 32'd8);
      check_vec("all_wb1_at", 32'(w1), 32'd16);
      check_vec("all_wb2_at", 32'(w2), 32'd24);

      // Low and high only
      run_sample(0, 3'b101, 2, 0, 0, la, w0, w1, w2);
      check_vec("lh_listo_at", 32'(la), 32'd17);
      check_vec("lh_wb0_at", 32'(w0), 32'd8);
      check_vec("lh_wb1_at", 32'(w1), 32'd16);
      check_vec("lh_wb2_none", 32'(w2), 32'd0);

      // No bands
      run_sample(0, 3'b000, 2, 0, 0, la, w0, w1, w2);
      check_vec("none_listo_at", 32'(la), 32'd1);
      check_vec("none_wb_none", 32'(w0), 32'd0);
      check_vec("no_overrun_yet", {31'd0, ovr(0)}, 32'd0);

      // Enables at k+10 and during DONE are ignored and set overrun
      run_sample(0, 3'b111, 2, 10, 25, la, w0, w1, w2);
      check_vec("ovr_listo_at", 32'(la), 32'd25);
      check_vec("ovr_wb2_at", 32'(w2), 32'd24);
      check_vec("ovr_set", {31'd0, ovr(0)}, 32'd1);
      run_sample(0, 3'b011, 2, 0, 0, la, w0, w1, w2);
      check_vec("ovr_next_listo_at", 32'(la), 32'd17);
      check_vec("ovr_sticky", {31'd0, ovr(0)}, 32'd1);

      // Reset at k+12 abandons the sample
      drive(0, 1'b1, 3'b111);
      step();
      drive(0, 1'b0, 3'b111);
      for (int t = 1; t < 12; t++) step();
      check_vec("abort_pre", {16'h0, snap(0)},
                {16'h0, mk(1, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)});
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check_vec("abort_outs", {16'h0, snap(0)}, 32'd0);
      check_vec("abort_ovr", {31'd0, ovr(0)}, 32'd0);
      hits = 0;
      for (int t = 0; t < 30; t++) begin
         s = snap(0);
         if (s[0] || s[1] || s[3] || s[8]) hits++;
         step();
      end
      check_vec("abort_quiet", 32'(hits), 32'd0);
      run_sample(0, 3'b111, 2, 0, 0, la, w0, w1, w2);
      check_vec("post_abort_listo_at", 32'(la), 32'd25);

      // MAC_LAT = 5
      run_sample(1, 3'b111, 5, 0, 0, la, w0, w1, w2);
      check_vec("lat5_listo_at", 32'(la), 32'd34);
      check_vec("lat5_wb0_at", 32'(w0), 32'd11);
      check_vec("lat5_wb1_at", 32'(w1), 32'd22);
      check_vec("lat5_wb2_at", 32'(w2), 32'd33);
      check_vec("lat5_no_ovr", {31'd0, ovr(1)}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/filter_band_scheduler.md
Name: filter_band_scheduler

Overview:
- Sequencer that time-shares one MAC datapath across the low, mid and high band biquad sections of the three-band filter bank.
- On each sample strobe from the frequency divider it steps through the bands in order. For each band it issues five coefficient/tap reads to the shared MAC, waits out the MAC pipeline, then writes the band output back and shifts that band's delay line.
- Sits between the divider and the shared MAC/coefficient ROM/state-register datapath, and regenerates Listo once all three band outputs are valid.

Parameters:
- MAC_LAT, default 2, MAC pipeline latency in cycles from the last mac_en to a valid accumulator (legal range 1..7).
- NBANDS, default 3, number of bands, fixed at 3 by the package constant.
- NTAPS, default 5, taps per biquad section (b0, b1, b2, a1, a2), fixed.

Ports:
- CLK  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  one-cycle sample strobe from the divider
- band_en  in  3  per-band enable; bit0 low, bit1 mid, bit2 high; sampled on the Enable cycle
- band  out  2  band currently being processed (0 low, 1 mid, 2 high)
- tap  out  3  current tap index 0..4
- coef_addr  out  4  coefficient ROM address, equal to band*5+tap
- mac_en  out  1  MAC consumes operands this cycle
- mac_clr  out  1  load instead of accumulate (asserted with tap 0)
- mac_sub  out  1  subtract the product (taps 3, 4 = a1*y1, a2*y2)
- wb_en  out  1  write accumulator to the output register of `band`
- shift_en  out  1  shift the delay line of `band` (u1<-u, u2<-u1, y1<-y, y2<-y1)
- busy  out  1  a sample is being processed
- Listo  out  1  one-cycle pulse: all enabled band outputs updated
- overrun  out  1  sticky: an Enable arrived while busy

Behaviour:
- Reset: state IDLE; every output 0, including band, tap, coef_addr and overrun. Reset wins over every other input, including mid-sample; the partial sample is abandoned and no wb_en or Listo is produced.
- Machine style: Moore. All outputs decode from registered state/counters; no combinational path from inputs to outputs.
- States: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE -> MAC when Enable=1 and band_en!=0. band_en is latched and band = lowest enabled band.
- IDLE -> DONE when Enable=1 and band_en=0. Listo pulses; no MAC activity occurs.
- MAC lasts 5 cycles, tap 0..4:
  - mac_en=1 on every MAC cycle.
  - mac_clr=1 only at tap 0.
  - mac_sub=1 at taps 3 and 4.
- DRAIN lasts MAC_LAT cycles; mac_en=0, tap holds 4.
- WRITE lasts 1 cycle with wb_en=shift_en=1. It then goes to MAC of the next higher enabled band, or to DONE if none remains.
- DONE lasts 1 cycle with Listo=1, then returns to IDLE.
- Cycles per enabled band: 6+MAC_LAT. With the default and all bands enabled, sample processing takes 24 cycles plus 1 DONE cycle.
- Timing: if Enable is high in cycle k, MAC tap 0 is in cycle k+1 and Listo is in cycle k+25 (default MAC_LAT). The divider period must be >= 26 cycles.
- busy=1 from the first MAC/DONE cycle through DONE inclusive.
- An Enable while busy=1 (including during DONE) is ignored and sets overrun=1. overrun clears only on Reset.
- band_en changes while busy are ignored until the next accepted Enable.
- coef_addr is always band*5+tap and is held stable during DRAIN and WRITE. It is 0 in IDLE and DONE.
- band and tap read 0 in IDLE and DONE.

Decomposition:
- Shared package filtro_pkg holds:
  - NBANDS=3, NTAPS=5
  - band encodings BAND_LOW=0, BAND_MID=1, BAND_HIGH=2
  - tap indices TAP_B0..TAP_A2
  - state encoding
  - function next_band(band_en, band)
- Natural sub-module: tap_counter. It is a loadable counter used for both the tap (0..4) and drain (0..MAC_LAT-1) counts, with a terminal-count output that drives FSM transitions.

Test Plan:
- Reset, then Enable with band_en=3'b111 -> cycles k+1..k+5 coef_addr 0..4 with mac_clr only at k+1 and mac_sub at k+4,k+5. wb_en at k+8 (band 0), k+16 (band 1), k+24 (band 2, coef_addr 14). Listo at k+25; busy low at k+26.
- band_en=3'b101 -> only bands 0 and 2 are processed; wb_en at k+8 and k+16 with band=2. Listo at k+17; coef_addr never in 5..9.
- band_en=3'b000 with Enable -> Listo at k+1, busy high only at k+1; mac_en and wb_en never asserted.
- Second Enable at k+10 and another during DONE -> both ignored, overrun=1 and stays 1. The first sample completes normally; the next Enable in IDLE starts a new sample.
- Reset asserted at k+12 -> next cycle all outputs 0 and IDLE; no wb_en or Listo from the aborted sample. A subsequent Enable runs a full 25-cycle sequence.
- MAC_LAT=5 build, all bands -> wb_en at k+11, k+22, k+33; Listo at k+34.
